codec_cmd_arbiter: RTL
======================

// Module: codec_cmd_arbiter
// PURPOSE
//   Shares the audio codec's single I2C register-write port (manual send/register/data/done
//   handshake on the codec init block) between NUM_REQ requesters: bypass switch, volume,
//   effect select, etc. Round-robin grant, one transaction at a time.
//   Enforces an inter-command gap and a done timeout. Counts completed writes.
// PARAMETERS
//   NUM_REQ        4       number of requesters (2..8)
//   GAP_CYCLES     64      idle clks between transactions (>=1)
//   TIMEOUT_CYCLES 500000  clks in SEND without done before abort (10 ms @ 50 MHz)
// PORTS
//   clk             in   1          50 MHz system clock
//   rst             in   1          asynchronous, active-low reset
//   init_done       in   1          codec init complete; no grants while 0
//   req             in   NUM_REQ    level request per requester
//   req_reg         in   NUM_REQ*7  codec register addr, requester i at [7i+6:7i]
//   req_data        in   NUM_REQ*9  codec register data, requester i at [9i+8:9i]
//   ack             out  NUM_REQ    1-clk pulse: write of requester i completed
//   nack            out  NUM_REQ    1-clk pulse: write of requester i timed out
//   manual_send     out  1          held high for whole transaction
//   manual_register out  7          latched register addr
//   manual_data     out  9          latched register data
//   manual_done     in   1          pulse from codec init block: write finished
//   busy            out  1          high in SEND or GAP
//   grant_id        out  3          index of current/last granted requester
//   timeout_err     out  1          sticky; set on any timeout, cleared only by reset
//   cmd_count       out  16         completed-write counter, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, all outputs 0, RR pointer 0, counters 0.
//   All outputs registered. States: IDLE, SEND, GAP.
//   IDLE: if init_done=1 and req!=0, pick the first set req at or after the RR pointer
//     (wrapping). On that edge: -> SEND, latch req_reg/req_data of winner into
//     manual_register/manual_data, grant_id=winner, manual_send=1, timeout cnt=0,
//     RR pointer=(winner+1) mod NUM_REQ.
//     Latency: req seen high at edge N -> manual_send high after edge N.
//   SEND: manual_send=1; payload and grant frozen; req/req_reg/req_data changes ignored.
//     manual_done=1 -> next edge: manual_send=0, ack[grant_id]=1 for 1 clk,
//       cmd_count+1, -> GAP.
//     else timeout cnt reaches TIMEOUT_CYCLES-1 -> next edge: manual_send=0,
//       nack[grant_id]=1 for 1 clk, timeout_err=1, -> GAP.
//     manual_done and timeout in the same clk: done wins (ack, no nack).
//     init_done falling in SEND: current transaction completes normally.
//   GAP: count GAP_CYCLES clks, then -> IDLE. req ignored.
//     manual_done in GAP or IDLE is ignored.
//   Requester contract: hold req with stable payload until its ack/nack; drop req in
//     the ack/nack clk. A req dropped before grant is simply withdrawn (no ack).
//   Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
//   manual_register/manual_data keep last value outside SEND.
//   ack and nack are never both high; at most one bit of ack|nack is set per clk.
// TESTING
//   1 Single req[2] with reg=0x04, data=0x018; done after 10 clks -> send high 10 clks
//     with 0x04/0x018, ack[2] one pulse, cmd_count=1, busy low after GAP_CYCLES.
//   2 req=4'b1111 held, done after 5 clks each -> grants 0,1,2,3,0 in order;
//     gap of GAP_CYCLES between sends.
//   3 init_done=0 with req[0]=1 for 100 clks -> manual_send stays 0; raise init_done
//     -> grant on next edge.
//   4 No done for TIMEOUT_CYCLES (use 100) -> nack[grant] pulse at clk 100,
//     timeout_err=1, cmd_count unchanged, next request still served.
//   5 done arrives in the same clk the timeout expires -> ack only, timeout_err stays 0.
//   6 Assert rst mid-SEND -> all outputs 0 at once, RR pointer 0; after release,
//     req=4'b1010 -> grant_id=1 first.

Source files
------------

// File: rtl/codec_cmd_arbiter.sv
// Round-robin arbiter sharing the codec's single register-write port among NUM_REQ requesters.
// One transaction at a time, with an enforced idle gap and a done timeout.
module codec_cmd_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_done,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*7-1:0] req_reg,
  input  logic [NUM_REQ*9-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   nack,
  output logic                 manual_send,
  output logic [6:0]           manual_register,
  output logic [8:0]           manual_data,
  input  logic                 manual_done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 timeout_err,
  output logic [15:0]          cmd_count
);

  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [2:0]      PtrLast = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e               state_q, state_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [2:0]           grant_q, grant_d;
  logic                 send_q, send_d;
  logic [6:0]           reg_q, reg_d;
  logic [8:0]           data_q, data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   nack_q, nack_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;

  logic                 found;
  logic [2:0]           winner;
  logic [6:0]           win_reg;
  logic [8:0]           win_data;

  // First pending request at or after the round-robin pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_reg  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        winner   = 3'(idx);
        win_reg  = req_reg[7*idx +: 7];
        win_data = req_data[9*idx +: 9];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    send_d    = send_q;
    reg_d     = reg_q;
    data_d    = data_q;
    ack_d     = '0;
    nack_d    = '0;
    terr_d    = terr_q;
    cnt_d     = cnt_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (init_done && found) begin
          state_d  = StSend;
          grant_d  = winner;
          reg_d    = win_reg;
          data_d   = win_data;
          send_d   = 1'b1;
          to_cnt_d = '0;
          rr_ptr_d = (winner == PtrLast) ? 3'd0 : winner + 3'd1;
        end
      end
      StSend: begin
        // Done takes priority over a timeout expiring in the same cycle.
        if (manual_done) begin
          state_d   = StGap;
          send_d    = 1'b0;
          ack_d     = NUM_REQ'(1) << grant_q;
          cnt_d     = cnt_q + 16'd1;
          gap_cnt_d = '0;
        end else if (to_cnt_q == ToLast) begin
          state_d   = StGap;
          send_d    = 1'b0;
          nack_d    = NUM_REQ'(1) << grant_q;
          terr_d    = 1'b1;
          gap_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      send_q    <= 1'b0;
      reg_q     <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      nack_q    <= '0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      send_q    <= send_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign ack             = ack_q;
  assign nack            = nack_q;
  assign manual_send     = send_q;
  assign manual_register = reg_q;
  assign manual_data     = data_q;
  assign busy            = busy_q;
  assign grant_id        = grant_q;
  assign timeout_err     = terr_q;
  assign cmd_count       = cnt_q;

endmodule
